// File: rtl/sequenciador_soma.sv
// Sequencer for a half-precision adder datapath: walks a batch of operand-pair
// words in memory and hands out one sum per pair over a valid/ready port.
// Latency: 5 cycles per pair minimum (READ, LOAD, EXEC, CAPT, OUT) plus one FIN cycle.
// Backpressure: OUT holds res_valid/res_data/res_index until res_ready; nothing else stalls.
//
// Ports:
//   clock, reset (async active-low), start, abort        - control
//   base_addr, n_ops                                      - batch descriptor, latched on start
//   endereco_Memoria, hab_Leitura, hab_Leitura_           - memory read side
//   hab_EscritaBR, controle_normaliza, controle_Resultado - datapath strobes
//   resultado                                             - sum from the datapath
//   res_data, res_index, res_valid, res_ready             - result handshake
//   busy, done, exc_count                                 - status
//
// Optional feature: define SEQ_EXCEPTION_EN to count results whose exponent field
// is all ones (Inf/NaN). Without it exc_count is tied to zero.

module sequenciador_soma (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  base_addr,
  input  logic [7:0]  n_ops,
  output logic [7:0]  endereco_Memoria,
  output logic        hab_Leitura,
  output logic        hab_Leitura_,
  output logic        hab_EscritaBR,
  output logic        controle_normaliza,
  output logic        controle_Resultado,
  input  logic [15:0] resultado,
  output logic [15:0] res_data,
  output logic [7:0]  res_index,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  exc_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_EXEC = 3'd3,
    S_CAPT = 3'd4,
    S_OUT  = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  nops_q, nops_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  rindex_q, rindex_d;
  logic [8:0]  idx_inc;

  // Nine bits so that n_ops = 255 compares correctly after the last pair.
  assign idx_inc = {1'b0, idx_q} + 9'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      nops_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      rindex_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      nops_q   <= nops_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      rindex_q <= rindex_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    nops_d   = nops_q;
    idx_d    = idx_q;
    data_d   = data_q;
    rindex_d = rindex_q;

    // Abort takes priority over everything, including a same-cycle handshake
    // in OUT and the capture in CAPT.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (n_ops != 8'd0) begin
              base_d  = base_addr;
              nops_d  = n_ops;
              idx_d   = '0;
              state_d = S_READ;
            end else begin
              state_d = S_FIN;
            end
          end
        end
        S_READ: state_d = S_LOAD;
        S_LOAD: state_d = S_EXEC;
        S_EXEC: state_d = S_CAPT;
        S_CAPT: begin
          data_d   = resultado;
          rindex_d = idx_q;
          state_d  = S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            idx_d   = idx_inc[7:0];
            state_d = (idx_inc < {1'b0, nops_q}) ? S_READ : S_FIN;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded straight from the state register so that an async
  // reset clears them without waiting for a clock edge.
  always_comb begin
    hab_Leitura        = 1'b0;
    hab_Leitura_       = 1'b0;
    hab_EscritaBR      = 1'b0;
    controle_normaliza = 1'b0;
    controle_Resultado = 1'b0;
    res_valid          = 1'b0;
    done               = 1'b0;
    endereco_Memoria   = '0;
    case (state_q)
      S_READ: begin
        endereco_Memoria = base_q + idx_q;
        hab_Leitura      = 1'b1;
        hab_Leitura_     = 1'b1;
      end
      S_LOAD: begin
        endereco_Memoria = base_q + idx_q;
        hab_EscritaBR    = 1'b1;
      end
      S_EXEC: controle_normaliza = 1'b1;
      S_CAPT: begin
        controle_normaliza = 1'b1;
        controle_Resultado = 1'b1;
      end
      S_OUT:   res_valid = 1'b1;
      S_FIN:   done      = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign res_data  = data_q;
  assign res_index = rindex_q;

`ifdef SEQ_EXCEPTION_EN
  logic [7:0] exc_q, exc_d;
  logic       start_acc;
  logic       capt_fire;

  assign start_acc = (state_q == S_IDLE) && start;
  assign capt_fire = (state_q == S_CAPT) && !abort;

  always_comb begin
    exc_d = exc_q;
    if (start_acc) begin
      exc_d = '0;
    end else if (capt_fire && (resultado[14:10] == 5'b11111) && (exc_q != 8'hFF)) begin
      exc_d = exc_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) exc_q <= '0;
    else        exc_q <= exc_d;
  end

  assign exc_count = exc_q;
`else
  assign exc_count = '0;
`endif

endmodule

// File: tb/tb_sequenciador_soma.sv
module tb_sequenciador_soma;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  base_addr;
  logic [7:0]  n_ops;
  logic [7:0]  endereco_Memoria;
  logic        hab_Leitura;
  logic        hab_Leitura_;
  logic        hab_EscritaBR;
  logic        controle_normaliza;
  logic        controle_Resultado;
  logic [15:0] resultado;
  logic [15:0] res_data;
  logic [7:0]  res_index;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic [7:0]  exc_count;

  int checks = 0;
  int errors = 0;

  sequenciador_soma dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .base_addr          (base_addr),
    .n_ops              (n_ops),
    .endereco_Memoria   (endereco_Memoria),
    .hab_Leitura        (hab_Leitura),
    .hab_Leitura_       (hab_Leitura_),
    .hab_EscritaBR      (hab_EscritaBR),
    .controle_normaliza (controle_normaliza),
    .controle_Resultado (controle_Resultado),
    .resultado          (resultado),
    .res_data           (res_data),
    .res_index          (res_index),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .busy               (busy),
    .done               (done),
    .exc_count          (exc_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a start pulse; returns in cycle 1 of the batch.
  task automatic start_batch(input logic [7:0] b, input logic [7:0] n);
    base_addr = b;
    n_ops     = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  logic [7:0] exc_exp;

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    n_ops     = '0;
    resultado = '0;
    res_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy",  {15'd0, busy},        16'd0);
    chk("rst_done",  {15'd0, done},        16'd0);
    chk("rst_valid", {15'd0, res_valid},   16'd0);
    chk("rst_rd",    {15'd0, hab_Leitura}, 16'd0);
    chk("rst_addr",  {8'd0, endereco_Memoria}, 16'd0);
    chk("rst_data",  res_data,             16'd0);
    chk("rst_exc",   {8'd0, exc_count},    16'd0);
    reset = 1'b1;
    tick();

    // Two pairs at 0x10, ready held high: reads on cycles 1 and 6,
    // results valid on cycles 5 and 10, done on cycle 11.
    res_ready = 1'b1;
    resultado = 16'h1111;
    start_batch(8'h10, 8'd2);
    for (int c = 1; c <= 12; c++) begin
      resultado = (c < 6) ? 16'h1111 : 16'h2222;
      chk($sformatf("t1_rd_c%0d", c),   {15'd0, hab_Leitura},  {15'd0, (c == 1 || c == 6)});
      chk($sformatf("t1_ce_c%0d", c),   {15'd0, hab_Leitura_}, {15'd0, (c == 1 || c == 6)});
      chk($sformatf("t1_br_c%0d", c),   {15'd0, hab_EscritaBR}, {15'd0, (c == 2 || c == 7)});
      chk($sformatf("t1_nrm_c%0d", c),  {15'd0, controle_normaliza},
          {15'd0, (c == 3 || c == 4 || c == 8 || c == 9)});
      chk($sformatf("t1_res_c%0d", c),  {15'd0, controle_Resultado}, {15'd0, (c == 4 || c == 9)});
      chk($sformatf("t1_vld_c%0d", c),  {15'd0, res_valid},  {15'd0, (c == 5 || c == 10)});
      chk($sformatf("t1_done_c%0d", c), {15'd0, done},       {15'd0, (c == 11)});
      chk($sformatf("t1_busy_c%0d", c), {15'd0, busy},       {15'd0, (c <= 11)});
      if (c == 1 || c == 2) chk("t1_addr0", {8'd0, endereco_Memoria}, 16'h0010);
      if (c == 6 || c == 7) chk("t1_addr1", {8'd0, endereco_Memoria}, 16'h0011);
      if (c == 5) begin
        chk("t1_data0", res_data, 16'h1111);
        chk("t1_idx0",  {8'd0, res_index}, 16'd0);
      end
      if (c == 10) begin
        chk("t1_data1", res_data, 16'h2222);
        chk("t1_idx1",  {8'd0, res_index}, 16'd1);
      end
      tick();
    end

    // n_ops = 0: straight to FIN, no memory access, busy for one cycle.
    start_batch(8'h40, 8'd0);
    chk("t2_done", {15'd0, done},        16'd1);
    chk("t2_busy", {15'd0, busy},        16'd1);
    chk("t2_rd",   {15'd0, hab_Leitura}, 16'd0);
    tick();
    chk("t2_done_off", {15'd0, done},        16'd0);
    chk("t2_busy_off", {15'd0, busy},        16'd0);
    chk("t2_rd_off",   {15'd0, hab_Leitura}, 16'd0);

    // Backpressure: ready low for 4 OUT cycles; a mid-batch start is ignored.
    res_ready = 1'b0;
    resultado = 16'hABCD;
    start_batch(8'h20, 8'd2);
    base_addr = 8'h80;
    n_ops     = 8'd0;
    start     = 1'b1;
    tick();                       // cycle 2
    start     = 1'b0;
    tick(); tick(); tick();       // cycle 5
    resultado = 16'h0000;
    for (int c = 5; c <= 8; c++) begin
      chk($sformatf("t3_vld_c%0d", c),  {15'd0, res_valid},   16'd1);
      chk($sformatf("t3_data_c%0d", c), res_data,             16'hABCD);
      chk($sformatf("t3_idx_c%0d", c),  {8'd0, res_index},    16'd0);
      chk($sformatf("t3_rd_c%0d", c),   {15'd0, hab_Leitura}, 16'd0);
      if (c == 8) res_ready = 1'b1;
      tick();
    end
    chk("t3_rd_after", {15'd0, hab_Leitura},      16'd1);
    chk("t3_addr",     {8'd0, endereco_Memoria},  16'h0021);
    repeat (5) tick();            // cycle 14
    chk("t3_done", {15'd0, done}, 16'd1);
    tick();

    // Address wrap: base 0xFF, two pairs.
    start_batch(8'hFF, 8'd2);
    chk("t4_addr0", {8'd0, endereco_Memoria}, 16'h00FF);
    repeat (5) tick();            // cycle 6
    chk("t4_rd1",   {15'd0, hab_Leitura},     16'd1);
    chk("t4_addr1", {8'd0, endereco_Memoria}, 16'h0000);
    repeat (5) tick();            // cycle 11
    chk("t4_done", {15'd0, done}, 16'd1);
    tick();

    // Abort during EXEC of pair 1 (cycle 8).
    start_batch(8'h00, 8'd2);
    repeat (7) tick();            // cycle 8
    chk("t5_exec", {15'd0, controle_normaliza}, 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", {15'd0, busy},               16'd0);
    chk("t5_nrm",  {15'd0, controle_normaliza}, 16'd0);
    chk("t5_vld",  {15'd0, res_valid},          16'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t5_nodone_%0d", c), {15'd0, done}, 16'd0);
      tick();
    end

    // Asynchronous reset while in OUT.
    res_ready = 1'b0;
    resultado = 16'h5555;
    start_batch(8'h30, 8'd1);
    repeat (4) tick();            // cycle 5
    chk("t6_vld_pre", {15'd0, res_valid}, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_vld_async",  {15'd0, res_valid},  16'd0);
    chk("t6_data_async", res_data,            16'd0);
    chk("t6_busy_async", {15'd0, busy},       16'd0);
    tick();
    reset = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t6_nodone_%0d", c), {15'd0, done}, 16'd0);
      chk($sformatf("t6_idle_%0d", c),   {15'd0, busy}, 16'd0);
      tick();
    end

    // Inf results on both pairs.
`ifdef SEQ_EXCEPTION_EN
    exc_exp = 8'd2;
`else
    exc_exp = 8'd0;
`endif
    resultado = 16'h7C00;
    start_batch(8'h50, 8'd2);
    repeat (10) tick();           // cycle 11
    chk("t7_done", {15'd0, done},      16'd1);
    chk("t7_exc",  {8'd0, exc_count},  {8'd0, exc_exp});
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
